dco_phase_ctl: RTL and testbench



---
 rtl/dco_phase_ctl.sv | 205 ++++++++++++++++++++
 tb/tb_dco_phase_ctl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dco_phase_ctl.sv
// Bring-up sequencer and PSEN/PSDONE phase-step controller for the LVDS DCO clock path.
// Runs entirely in the phase-shift clock domain; mmcm_locked is the only asynchronous input.
module dco_phase_ctl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned PS_TIMEOUT    = 1023,
    parameter int unsigned PHASE_W       = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      restart,
    input  logic                      mmcm_locked,
    output logic                      clk_reset,
    output logic                      mmcm_reset,
    output logic                      mmcm_psen,
    output logic                      mmcm_psincdec,
    input  logic                      mmcm_psdone,
    input  logic                      cmd_valid,
    input  logic                      cmd_dir,
    input  logic [7:0]                cmd_count,
    output logic                      cmd_ready,
    output logic                      cmd_done,
    output logic                      ready,
    output logic signed [PHASE_W-1:0] phase,
    output logic                      err_lock,
    output logic                      err_ps,
    input  logic                      err_clr
);

    localparam int unsigned MaxRs  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MaxTo  = (LOCK_TIMEOUT > PS_TIMEOUT) ? LOCK_TIMEOUT : PS_TIMEOUT;
    localparam int unsigned MaxCnt = (MaxRs > MaxTo) ? MaxRs : MaxTo;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    // Each limit is the last cycle index spent in the state, counted from 0 on entry.
    localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] PsLast     = CntW'(PS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StInit,
        StSettle,
        StWaitLock,
        StIdle,
        StPsPulse,
        StPsWait
    } state_e;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [7:0]                rem_q, rem_d;
    logic                      dir_q, dir_d;
    logic signed [PHASE_W-1:0] phase_q, phase_d;
    logic                      done_q, done_d;
    logic                      err_lock_q, err_ps_q;
    logic                      set_lock, set_ps;
    logic [1:0]                sync_q;
    logic                      locked_s;

    assign locked_s = sync_q[1];

    // Held clear while the MMCM is in reset so a stale LOCKED cannot short-cut WAIT_LOCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else if (mmcm_reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], mmcm_locked};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntW'(1);
        rem_d    = rem_q;
        dir_d    = dir_q;
        phase_d  = phase_q;
        done_d   = 1'b0;
        set_lock = 1'b0;
        set_ps   = 1'b0;

        unique case (state_q)
            StInit: begin
                if (cnt_q == RstLast) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            end
            StWaitLock: begin
                if (locked_s) begin
                    state_d = StIdle;
                end else if (cnt_q == LockLast) begin
                    set_lock = 1'b1;
                    state_d  = StInit;
                    cnt_d    = '0;
                end
            end
            StIdle: begin
                if (!locked_s) begin
                    set_lock = 1'b1;
                    state_d  = StInit;
                    cnt_d    = '0;
                end else if (cmd_valid && cmd_ready) begin
                    dir_d = cmd_dir;
                    rem_d = cmd_count;
                    if (cmd_count == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StPsPulse;
                    end
                end
            end
            StPsPulse: begin
                if (!locked_s) begin
                    set_lock = 1'b1;
                    state_d  = StInit;
                    cnt_d    = '0;
                end else begin
                    state_d = StPsWait;
                    cnt_d   = '0;
                end
            end
            StPsWait: begin
                if (!locked_s) begin
                    set_lock = 1'b1;
                    state_d  = StInit;
                    cnt_d    = '0;
                end else if (mmcm_psdone) begin
                    phase_d = dir_q ? phase_q + PHASE_W'(1) : phase_q - PHASE_W'(1);
                    rem_d   = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StPsPulse;
                    end
                end else if (cnt_q == PsLast) begin
                    // Missing step leaves phase untouched; the burst is closed out.
                    set_ps  = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase

        if (restart) begin
            state_d  = StInit;
            cnt_d    = '0;
            done_d   = 1'b0;
            set_lock = 1'b0;
            set_ps   = 1'b0;
        end

        if (state_d == StInit) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            rem_q      <= 8'd0;
            dir_q      <= 1'b0;
            phase_q    <= '0;
            done_q     <= 1'b0;
            err_lock_q <= 1'b0;
            err_ps_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dir_q      <= dir_d;
            phase_q    <= phase_d;
            done_q     <= done_d;
            err_lock_q <= (err_lock_q & ~err_clr) | set_lock;
            err_ps_q   <= (err_ps_q & ~err_clr) | set_ps;
        end
    end

    assign clk_reset     = (state_q == StInit);
    assign mmcm_reset    = (state_q == StInit) || (state_q == StSettle);
    assign mmcm_psen     = (state_q == StPsPulse);
    assign mmcm_psincdec = dir_q;
    assign ready         = (state_q == StIdle);
    assign cmd_ready     = ready & ~restart;
    assign cmd_done      = done_q;
    assign phase         = phase_q;
    assign err_lock      = err_lock_q;
    assign err_ps        = err_ps_q;

endmodule

// File: tb/tb_dco_phase_ctl.sv
// Self-checking bench for dco_phase_ctl: bring-up timing, step bursts, wrap, timeouts,
// lock loss, restart collision and randomized bursts against a step-count phase model.
module tb_dco_phase_ctl;

    localparam int RstC   = 16;
    localparam int SetC   = 8;
    localparam int LockTo = 200;
    localparam int PsTo   = 40;
    localparam int PW     = 4;

    logic                 clk = 1'b0;
    logic                 rst_n, restart, mmcm_locked, mmcm_psdone;
    logic                 cmd_valid, cmd_dir, err_clr;
    logic [7:0]           cmd_count;
    logic                 clk_reset, mmcm_reset, mmcm_psen, mmcm_psincdec;
    logic                 cmd_ready, cmd_done, ready, err_lock, err_ps;
    logic signed [PW-1:0] phase;

    dco_phase_ctl #(
        .RST_CYCLES   (RstC),
        .SETTLE_CYCLES(SetC),
        .LOCK_TIMEOUT (LockTo),
        .PS_TIMEOUT   (PsTo),
        .PHASE_W      (PW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .mmcm_locked  (mmcm_locked),
        .clk_reset    (clk_reset),
        .mmcm_reset   (mmcm_reset),
        .mmcm_psen    (mmcm_psen),
        .mmcm_psincdec(mmcm_psincdec),
        .mmcm_psdone  (mmcm_psdone),
        .cmd_valid    (cmd_valid),
        .cmd_dir      (cmd_dir),
        .cmd_count    (cmd_count),
        .cmd_ready    (cmd_ready),
        .cmd_done     (cmd_done),
        .ready        (ready),
        .phase        (phase),
        .err_lock     (err_lock),
        .err_ps       (err_ps),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic dir;
        int   count;
        int   delay;
        int   exp_phase;
        int   exp_psen;
    } vec_t;

    typedef struct packed {
        int n_psen;
        int n_done;
        int bad;
        int acc;
        int first_psen;
        int last_psen;
        int last_psdone;
        int done_cyc;
        int errps_cyc;
    } res_t;

    int n_checks = 0;
    int n_err    = 0;
    int cyc_n    = 0;
    int model_phase;
    int trace[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Two's-complement wrap of an integer step count into PW bits.
    function automatic int wrap(input int v);
        int m;
        int r;
        m = 1 << PW;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic wait_cmd_ready(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    // Issues one burst and plays the MMCM: psdone 'delay' cycles after each psen, except
    // for step number 'drop_step' (1-based, 0 = none) which never completes.
    task automatic run_burst(input logic dir, input int count, input int delay,
                             input int drop_step, output res_t r);
        int   pend;
        int   tail;
        logic psd;
        logic prev_psen;
        bit   ok;
        r = '0;
        r.first_psen  = -1;
        r.last_psen   = -1;
        r.last_psdone = -1;
        r.done_cyc    = -1;
        r.errps_cyc   = -1;
        pend = 0;
        tail = -1;
        psd = 1'b0;
        prev_psen = 1'b0;
        wait_cmd_ready(200, ok);
        if (!ok) begin
            r.bad = 1;
            return;
        end
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_count = 8'(count);
        r.acc     = cyc_n;
        for (int i = 0; i < 1500; i++) begin
            cyc();
            cmd_valid = 1'b0;
            if (psd) begin
                model_phase = wrap(model_phase + (dir ? 1 : -1));
                trace.push_back(int'(phase));
            end
            if (int'(phase) != model_phase) r.bad++;
            if (err_ps && r.errps_cyc < 0) r.errps_cyc = cyc_n;
            if (mmcm_psen) begin
                r.n_psen++;
                if (r.first_psen < 0) r.first_psen = cyc_n;
                r.last_psen = cyc_n;
                if (prev_psen || pend > 0) r.bad++;
                if (mmcm_psincdec !== dir) r.bad++;
            end
            if (pend > 0 && mmcm_psincdec !== dir) r.bad++;
            if (cmd_done) begin
                r.n_done++;
                if (r.done_cyc < 0) r.done_cyc = cyc_n;
                if (tail < 0) tail = 5;
            end
            prev_psen = mmcm_psen;
            psd = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    psd = 1'b1;
                    r.last_psdone = cyc_n;
                end
            end
            if (mmcm_psen && r.n_psen != drop_step) pend = delay;
            mmcm_psdone = psd;
            if (tail > 0) begin
                tail--;
                if (tail == 0) break;
            end
        end
        mmcm_psdone = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        res_t r;
        int   fall_clr, fall_mr, rdy, lock_cyc;
        int   n_psen, n_done, pend, drop_c, init_c, el, rd, ph, fr, rr, el_at_rr, el_before;
        int   p0, exp_ph, cnt, dly, drop;
        logic dir, prev_el;
        bit   ok;

        vecs[0] = '{1'b1, 5, 12, 5, 5};
        vecs[1] = '{1'b1, 7, 3, -4, 7};
        vecs[2] = '{1'b0, 0, 2, -4, 0};
        vecs[3] = '{1'b0, 3, 1, -7, 3};

        rst_n = 1'b0; restart = 1'b0; mmcm_locked = 1'b0; mmcm_psdone = 1'b0;
        cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_count = 8'd0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_reset", int'(clk_reset), 1);
        check("rst_mmcm_reset", int'(mmcm_reset), 1);
        check("rst_psen", int'(mmcm_psen), 0);
        check("rst_psincdec", int'(mmcm_psincdec), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_cmd_done", int'(cmd_done), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_errs", int'({err_lock, err_ps}), 0);

        // Bring-up: cycle 0 is the first cycle with rst_n released.
        rst_n = 1'b1;
        cyc_n = 0;
        fall_clr = -1; fall_mr = -1; rdy = -1; lock_cyc = -100;
        for (int i = 0; i < 120; i++) begin
            if (fall_clr < 0 && !clk_reset) fall_clr = cyc_n;
            if (fall_mr < 0 && !mmcm_reset) fall_mr = cyc_n;
            if (fall_mr >= 0 && cyc_n == fall_mr + 20) begin
                mmcm_locked = 1'b1;
                lock_cyc = cyc_n;
            end
            if (ready) begin
                rdy = cyc_n;
                break;
            end
            cyc();
        end
        check("bringup_clk_reset_fall", fall_clr, RstC);
        check("bringup_mmcm_reset_fall", fall_mr, RstC + SetC);
        check("bringup_ready_after_lock", rdy - lock_cyc, 3);
        check("bringup_phase", int'(phase), 0);
        check("bringup_err_lock", int'(err_lock), 0);
        check("bringup_cmd_ready", int'(cmd_ready), 1);
        model_phase = 0;

        for (int i = 0; i < 4; i++) begin
            run_burst(vecs[i].dir, vecs[i].count, vecs[i].delay, 0, r);
            check($sformatf("vec%0d_psen", i), r.n_psen, vecs[i].exp_psen);
            check($sformatf("vec%0d_done", i), r.n_done, 1);
            check($sformatf("vec%0d_phase", i), int'(phase), vecs[i].exp_phase);
            check($sformatf("vec%0d_protocol", i), r.bad, 0);
            if (vecs[i].count == 0) begin
                check($sformatf("vec%0d_done_lat", i), r.done_cyc - r.acc, 1);
            end else begin
                check($sformatf("vec%0d_psen_lat", i), r.first_psen - r.acc, 1);
                check($sformatf("vec%0d_done_lat", i), r.done_cyc - r.last_psdone, 1);
            end
        end

        // Decrement through the negative wrap point.
        trace.delete();
        run_burst(1'b0, 3, 2, 0, r);
        check("wrap_steps", trace.size(), 3);
        if (trace.size() == 3) begin
            check("wrap_step0", trace[0], -8);
            check("wrap_step1", trace[1], 7);
            check("wrap_step2", trace[2], 6);
        end
        check("wrap_protocol", r.bad, 0);

        // Second step never completes.
        p0 = model_phase;
        run_burst(1'b1, 2, 3, 2, r);
        check("pst_psen", r.n_psen, 2);
        check("pst_done", r.n_done, 1);
        check("pst_errps_lat", r.errps_cyc - r.last_psen, PsTo + 1);
        check("pst_done_lat", r.done_cyc - r.last_psen, PsTo + 1);
        check("pst_phase", int'(phase), wrap(p0 + 1));
        check("pst_protocol", r.bad, 0);
        check("pst_idle", int'(cmd_ready), 1);
        check("pst_err_ps_held", int'(err_ps), 1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("pst_err_clr", int'(err_ps), 0);

        // Lock loss on the second step of a burst.
        wait_cmd_ready(50, ok);
        check("ll_idle", int'(ok), 1);
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_count = 8'd5;
        cyc();
        cmd_valid = 1'b0;
        n_psen = 0; n_done = 0; pend = 0; drop_c = -100; init_c = -1;
        el = -1; rd = -1; ph = -99;
        for (int i = 0; i < 40; i++) begin
            mmcm_psdone = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) mmcm_psdone = 1'b1;
            end
            if (mmcm_psen) begin
                n_psen++;
                if (n_psen == 1) pend = 2;
                if (n_psen == 2) begin
                    mmcm_locked = 1'b0;
                    drop_c = cyc_n;
                end
            end
            if (cmd_done) n_done++;
            if (init_c < 0 && clk_reset) begin
                init_c = cyc_n; el = int'(err_lock); rd = int'(ready); ph = int'(phase);
            end
            if (init_c >= 0 && cyc_n == init_c + 3) break;
            cyc();
        end
        mmcm_psdone = 1'b0;
        check("ll_psen", n_psen, 2);
        check("ll_init_lat", init_c - drop_c, 3);
        check("ll_err_lock", el, 1);
        check("ll_ready", rd, 0);
        check("ll_phase", ph, 0);
        check("ll_no_done", n_done, 0);

        // Lock held low: WAIT_LOCK must time out and re-enter INIT.
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("lt_err_clr", int'(err_lock), 0);
        fr = -1; rr = -1; el_at_rr = -1; el_before = -1; prev_el = err_lock;
        for (int i = 0; i < 400; i++) begin
            if (fr < 0 && !mmcm_reset) fr = cyc_n;
            if (fr >= 0 && rr < 0 && mmcm_reset) begin
                rr = cyc_n; el_at_rr = int'(err_lock); el_before = int'(prev_el);
                break;
            end
            prev_el = err_lock;
            cyc();
        end
        check("lt_settle_done", fr - init_c, RstC + SetC);
        check("lt_timeout_len", rr - fr, LockTo);
        check("lt_err_before", el_before, 0);
        check("lt_err_set", el_at_rr, 1);

        // Relock, then restart colliding with a command.
        mmcm_locked = 1'b1;
        wait_cmd_ready(100, ok);
        check("relock_ready", int'(ok), 1);
        restart = 1'b1; cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_count = 8'd3;
        #1;
        check("col_cmd_ready", int'(cmd_ready), 0);
        cyc();
        restart = 1'b0; cmd_valid = 1'b0;
        check("col_init_clk_reset", int'(clk_reset), 1);
        check("col_init_ready", int'(ready), 0);
        n_psen = 0; n_done = 0; rdy = -1;
        for (int i = 0; i < 100; i++) begin
            if (mmcm_psen) n_psen++;
            if (cmd_done) n_done++;
            if (ready) begin
                rdy = cyc_n;
                break;
            end
            cyc();
        end
        check("col_no_psen", n_psen, 0);
        check("col_no_done", n_done, 0);
        check("col_relocked", int'(rdy >= 0), 1);
        check("col_err_lock_kept", int'(err_lock), 1);
        check("col_phase", int'(phase), 0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("col_err_clr", int'(err_lock), 0);

        // Randomized bursts; expected phase is start + signed count of completed steps.
        model_phase = 0;
        for (int i = 0; i < 25; i++) begin
            dir  = 1'($urandom_range(0, 1));
            cnt  = int'($urandom_range(0, 6));
            dly  = int'($urandom_range(1, 10));
            drop = 0;
            if (cnt > 0 && $urandom_range(0, 4) == 0) drop = int'($urandom_range(1, cnt));
            exp_ph = wrap(model_phase + (dir ? 1 : -1) * ((drop != 0) ? drop - 1 : cnt));
            run_burst(dir, cnt, dly, drop, r);
            check($sformatf("rnd%0d_psen", i), r.n_psen, (drop != 0) ? drop : cnt);
            check($sformatf("rnd%0d_done", i), r.n_done, 1);
            check($sformatf("rnd%0d_phase", i), int'(phase), exp_ph);
            check($sformatf("rnd%0d_err_ps", i), int'(err_ps), int'(drop != 0));
            check($sformatf("rnd%0d_protocol", i), r.bad, 0);
            if (drop != 0) begin
                err_clr = 1'b1;
                cyc();
                err_clr = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
